// File: rtl/reg_write_scoreboard.sv
// Per-register saturating counters tracking in-flight writes from ID issue to WB retire.
// Optional SB_ERROR_CHECK_EN builds the sticky underflow/overflow error flag.
module reg_write_scoreboard #(
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic                 issue_wb_en,
    input  logic [ADDR_W-1:0]    issue_dest,
    input  logic [ADDR_W-1:0]    src1,
    input  logic [ADDR_W-1:0]    src2,
    input  logic                 have_two_src,
    input  logic                 ignore_hazard,
    input  logic                 retire_valid,
    input  logic [ADDR_W-1:0]    retire_dest,
    output logic                 stall,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 sb_error
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0]     count      [REG_COUNT];
    logic [CNT_W-1:0]     count_next [REG_COUNT];
    logic [REG_COUNT-1:0] busy_next;
    logic [REG_COUNT-1:0] inc_vec;
    logic [REG_COUNT-1:0] dec_vec;
    logic                 src_hit;
    logic                 sat_hit;
    logic                 accept;

    // Hazard decision uses only registered counts; a retire this cycle does not unblock until next cycle.
    always_comb begin
        src_hit = !ignore_hazard &&
                  ((count[src1] != '0) || (have_two_src && (count[src2] != '0)));
        sat_hit = issue_wb_en && (count[issue_dest] == MAX);
        stall   = issue_valid && !flush && (src_hit || sat_hit);
        accept  = issue_valid && issue_wb_en && !flush && !stall;
    end

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            inc_vec[r]    = accept && (issue_dest == ADDR_W'(r));
            dec_vec[r]    = retire_valid && (retire_dest == ADDR_W'(r));
            count_next[r] = count[r];
            if (clear) begin
                count_next[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                count_next[r] = count[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (count[r] != '0) begin
                    count_next[r] = count[r] - CNT_W'(1);
                end
            end else if (inc_vec[r] && dec_vec[r]) begin
                // A retire against an empty counter is discarded, so only the issue lands.
                if (count[r] == '0) begin
                    count_next[r] = CNT_W'(1);
                end
            end
            busy_next[r] = (count_next[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                count[r] <= '0;
            end
            busy_mask <= '0;
        end else begin
            count     <= count_next;
            busy_mask <= busy_next;
        end
    end

`ifdef SB_ERROR_CHECK_EN
    logic underflow;
    logic overflow;

    // Overflow cannot happen while sat_hit stalls the issue; it guards against that logic breaking.
    assign underflow = retire_valid && (count[retire_dest] == '0);
    assign overflow  = accept && (count[issue_dest] == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (underflow || overflow) begin
            sb_error <= 1'b1;
        end
    end
`else
    assign sb_error = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: directed test-plan steps followed by
// randomized traffic, all checked against an integer-count reference model.
module tb_reg_write_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        flush;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        have_two_src;
    logic        ignore_hazard;
    logic        retire_valid;
    logic [3:0]  retire_dest;
    logic        stall;
    logic [15:0] busy_mask;
    logic        sb_error;

    int checks = 0;
    int errors = 0;

    // Reference model: number of outstanding writes per register and the sticky error flag.
    int cnt_m [16];
    bit err_m;

    reg_write_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_wb_en   (issue_wb_en),
        .issue_dest    (issue_dest),
        .src1          (src1),
        .src2          (src2),
        .have_two_src  (have_two_src),
        .ignore_hazard (ignore_hazard),
        .retire_valid  (retire_valid),
        .retire_dest   (retire_dest),
        .stall         (stall),
        .busy_mask     (busy_mask),
        .sb_error      (sb_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wb, input logic [3:0] dest,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                 input logic ign, input logic rv, input logic [3:0] rd,
                                 input logic fl, input logic cl);
        issue_valid   = v;
        issue_wb_en   = wb;
        issue_dest    = dest;
        src1          = s1;
        src2          = s2;
        have_two_src  = two;
        ignore_hazard = ign;
        retire_valid  = rv;
        retire_dest   = rd;
        flush         = fl;
        clear         = cl;
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        for (int r = 0; r < 16; r++) m[r] = (cnt_m[r] > 0);
        return m;
    endfunction

    function automatic logic model_stall();
        bit reads_busy = !ignore_hazard && (cnt_m[src1] > 0 || (have_two_src && cnt_m[src2] > 0));
        bit full_dest  = issue_wb_en && cnt_m[issue_dest] == 3;
        return issue_valid && !flush && (reads_busy || full_dest);
    endfunction

    function automatic logic model_err();
`ifdef SB_ERROR_CHECK_EN
        return err_m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) cnt_m[r] = 0;
        err_m = 0;
    endtask

    // Check outputs for the current inputs, then advance the model across one clock edge.
    task automatic stepCycle(input string tag);
        bit exp_stall;
        bit acc;
        #2;
        exp_stall = model_stall();
        checkOutput({tag, ":stall"}, {15'd0, stall}, {15'd0, exp_stall});
        checkOutput({tag, ":busy"}, busy_mask, model_mask());
        checkOutput({tag, ":err"}, {15'd0, sb_error}, {15'd0, model_err()});
        @(posedge clk);
        acc = issue_valid && issue_wb_en && !flush && !exp_stall;
        if (retire_valid && cnt_m[retire_dest] == 0) err_m = 1;
        if (clear) begin
            for (int r = 0; r < 16; r++) cnt_m[r] = 0;
        end else begin
            int rd = int'(retire_dest);
            bit real_dec = retire_valid && cnt_m[rd] > 0;
            if (acc) cnt_m[issue_dest] = cnt_m[issue_dest] + 1;
            if (real_dec) cnt_m[rd] = cnt_m[rd] - 1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset:busy", busy_mask, 16'h0000);
        checkOutput("reset:err", {15'd0, sb_error}, 16'h0000);

        // Idle read of untouched registers
        applyStimulus(1, 0, 0, 2, 3, 1, 0, 0, 0, 0, 0);
        stepCycle("idle");

        // RAW hazard on r5, resolved by its retire
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("raw_issue");
        applyStimulus(1, 0, 0, 5, 0, 0, 0, 1, 5, 0, 0);
        #2;
        checkOutput("raw_stall_lit", {15'd0, stall}, 16'h0001);
        checkOutput("raw_busy_lit", busy_mask, 16'h0020);
        #(-0);
        stepCycle("raw_retire");
        applyStimulus(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("raw_clear");
        checkOutput("raw_after_lit", busy_mask, 16'h0000);

        // Saturation of r7
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
            stepCycle("sat_fill");
        end
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("sat_stall_lit", {15'd0, stall}, 16'h0001);
        stepCycle("sat_blocked");
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
        stepCycle("sat_retire");
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("sat_accept_lit", {15'd0, stall}, 16'h0000);
        stepCycle("sat_accept");

        // Simultaneous issue and retire on r4, then a flushed issue to r9
        applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("sim_first");
        applyStimulus(1, 1, 4, 0, 0, 0, 0, 1, 4, 0, 0);
        stepCycle("sim_both");
        applyStimulus(1, 1, 9, 7, 0, 0, 0, 0, 0, 1, 0);
        stepCycle("flush");
        checkOutput("sim_busy_lit", busy_mask, 16'h0090);

        // Underflow retire on empty r1
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        stepCycle("underflow");
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycle("clear_accept");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("after_clear");
        checkOutput("clear_busy_lit", busy_mask, 16'h0000);
`ifdef SB_ERROR_CHECK_EN
        checkOutput("err_sticky_lit", {15'd0, sb_error}, 16'h0001);
`else
        checkOutput("err_tied_lit", {15'd0, sb_error}, 16'h0000);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 31) == 0));
            stepCycle("rand");
        end

        // Async reset pulse between clock edges
        applyStimulus(1, 1, 6, 0, 0, 0, 1, 0, 0, 0, 0);
        stepCycle("pre_rst");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("async_rst_busy", busy_mask, 16'h0000);
        checkOutput("async_rst_err", {15'd0, sb_error}, 16'h0000);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("resume");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("resume_idle");
        checkOutput("resume_busy_lit", busy_mask, 16'h0008);

        $display("[TB] directed and random phases complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Tracks in-flight register writes between ID issue and WB retire. One saturating counter per architectural register.
- Raises a stall when an issuing instruction reads a register with pending writes, or when its destination counter is saturated.
- Sits beside the ID stage. It is the producer/tracker side of the destination-match information that hazard checking consumes. Issue arrives from ID; retire arrives from the WB stage.

Parameters:
- REG_COUNT, 16, number of architectural registers tracked
- ADDR_W, 4, register address width (clog2 of REG_COUNT)
- CNT_W, 2, per-register counter width; saturation value MAX = 2**CNT_W - 1 = 3

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- clear  input  1  synchronous clear of all counters
- flush  input  1  kills the instruction currently in ID; its issue is not recorded
- issue_valid  input  1  valid instruction in ID
- issue_wb_en  input  1  ID instruction writes a register
- issue_dest  input  ADDR_W  destination of the ID instruction
- src1  input  ADDR_W  first source register
- src2  input  ADDR_W  second source register
- have_two_src  input  1  src2 is meaningful
- ignore_hazard  input  1  instruction reads no registers (e.g. branch); source check disabled
- retire_valid  input  1  WB stage commits a write this cycle
- retire_dest  input  ADDR_W  register written by WB
- stall  output  1  hold ID/IF; issue not accepted
- busy_mask  output  REG_COUNT  bit i = 1 when count[i] != 0 (registered)
- sb_error  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all counters 0, busy_mask 0, sb_error 0. stall evaluates to 0 because all counts are 0.
- stall is combinational from registered counts. There is no same-cycle retire bypass: a retire in cycle N clears busy only from cycle N+1.
- stall = issue_valid & !flush & (src_hit | sat_hit), where:
  - src_hit = !ignore_hazard & ((count[src1]!=0) | (have_two_src & count[src2]!=0))
  - sat_hit = issue_wb_en & (count[issue_dest]==MAX)
- accept = issue_valid & issue_wb_en & !flush & !stall.
- Per register r, each cycle:
  - inc = accept & issue_dest==r; dec = retire_valid & retire_dest==r
  - inc & !dec: count+1
  - dec & !inc: count-1, except when count==0, where it holds at 0 (underflow)
  - inc & dec: unchanged; if count==0 the result is 1, i.e. the retire is treated as underflow and the issue is recorded
  - neither: hold
- clear has priority over inc/dec: all counts become 0 next cycle. clear does not reset sb_error.
- flush in the same cycle as issue_valid: no increment, stall=0.
- Retire continues during flush and during stall.
- busy_mask is registered and updates together with the counts.
- Asserting rst mid-operation zeroes all state immediately (asynchronous). Counting resumes on the first clk edge after deassertion.
- No state machine beyond the counters. Latency: issue is visible in busy_mask 1 cycle after accept.

Optional Feature:
- Macro SB_ERROR_CHECK_EN.
- Defined:
  - sb_error sets on the next edge when a retire hits count==0 (underflow, including the inc&dec case above).
  - sb_error also sets when an accept would exceed MAX. This is unreachable by construction; it is checked as an assertion-style guard.
  - sb_error is sticky until rst.
- Undefined: sb_error tied to 0 and no error logic is synthesized. Counter behaviour is identical either way.

Test Plan:
- Reset/idle: rst=1 then release; issue src1=2 src2=3 have_two_src=1 -> stall=0, busy_mask=0x0000.
- RAW stall: accept issue_dest=5; next cycle src1=5 -> stall=1; retire_dest=5 -> stall drops the cycle after the retire; busy_mask bit5 goes 1 then 0.
- Saturation: three accepted issues to dest=7 with no retire -> count=3. Fourth issue_wb_en dest=7 -> stall=1 and count stays 3. One retire of 7 -> next cycle the issue is accepted.
- Simultaneous issue+retire: count[4]=1, accept dest=4 with retire_dest=4 -> count[4]=1, bit4 stays set. Flush with issue dest=9 -> no increment, stall=0.
- Underflow/error (SB_ERROR_CHECK_EN defined): retire_dest=1 with count[1]=0 -> count stays 0, sb_error=1 next cycle, holds through clear, cleared only by rst. Undefined -> sb_error=0.
- Clear and async reset: counts nonzero; clear=1 with a simultaneous accept -> all counts 0 next cycle. rst pulse between clk edges -> busy_mask=0 immediately.
